// File: rtl/afpm_sig_divider.sv
// afpm_sig_divider: sequential radix-2 restoring divider for 24-bit IEEE-754
// significands (hidden bit included). One quotient bit per cycle, valid/ready
// on both sides, optional divisor LSB truncation via TRUNC_BITS.
// Optional feature macro: AFPM_DIV_EARLY_TERM_EN. When it is defined, the
// divider stops as soon as the partial remainder reaches zero. Quotient and
// sticky are the same either way; only the latency changes.
module afpm_sig_divider #(
  parameter int Q_BITS     = 26,
  parameter int TRUNC_BITS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       fp_sig_dividend,
  input  logic [31:0]       fp_sig_divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_BITS-1:0] fp_sig_quotient,
  output logic              sticky,
  output logic              div_by_zero
);

  localparam int CW = (Q_BITS > 1) ? $clog2(Q_BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       div_q, div_d;
  logic [Q_BITS-1:0] quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              dbz_q, dbz_d;

  // Truncate the divisor LSBs, folding the highest dropped bit into the
  // lowest kept bit so the truncated divisor never collapses too far.
  function automatic logic [23:0] eff_divisor(input logic [23:0] d);
    logic [23:0] r;
    logic        lsb;
    r   = d;
    lsb = 1'b0;
    for (int i = 0; i < 24; i++)
      if (i == TRUNC_BITS - 1) lsb = d[i];
    for (int i = 0; i < 24; i++) begin
      if (i < TRUNC_BITS) r[i] = 1'b0;
      else if (i == TRUNC_BITS) r[i] = d[i] | lsb;
    end
    return r;
  endfunction

  logic [23:0] div_eff;
  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_nxt;
  logic        unused_hi;

  assign div_eff = eff_divisor(fp_sig_divisor[23:0]);
  assign rem_ge  = (rem_q >= {1'b0, div_q});
  assign rem_sub = rem_q - {1'b0, div_q};
  // After a subtraction rem < div < 2^24, so the shifted value fits 25 bits.
  assign rem_nxt = rem_ge ? {rem_sub[23:0], 1'b0} : {rem_q[23:0], 1'b0};

  assign unused_hi = ^{fp_sig_dividend[31:24], fp_sig_divisor[31:24], rem_sub[24]};

  // State and datapath registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next-state logic: accept operands, iterate one quotient bit per cycle, hold result.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rem_d    = {1'b0, fp_sig_dividend[23:0]};
          div_d    = div_eff;
          quo_d    = '0;
          cnt_d    = CW'(Q_BITS - 1);
          sticky_d = 1'b0;
          dbz_d    = (div_eff == 24'd0);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (dbz_q) begin
          // Zero divisor: saturated quotient, flagged inexact, one cycle later.
          quo_d    = '1;
          sticky_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          quo_d[cnt_q] = rem_ge;
          rem_d        = rem_nxt;
          if (cnt_q == '0) begin
            sticky_d = (rem_nxt != 25'd0);
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`ifdef AFPM_DIV_EARLY_TERM_EN
          // Zero remainder: all remaining quotient bits are 0 and the result is exact.
          if (rem_nxt == 25'd0) begin
            sticky_d = 1'b0;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_DONE);
  assign fp_sig_quotient = quo_q;
  assign sticky          = sticky_q;
  assign div_by_zero     = dbz_q;

endmodule

// File: tb/tb_afpm_sig_divider.sv
// Directed testbench for afpm_sig_divider: exact, inexact, maximum-ratio,
// zero-dividend, truncated-divisor, divide-by-zero with backpressure and
// mid-operation reset vectors, with hand-computed expected values.
module tb_afpm_sig_divider;

`ifdef AFPM_DIV_EARLY_TERM_EN
  localparam int LAT_EQ   = 1;
  localparam int LAT_MAX  = 24;
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_EQ   = 26;
  localparam int LAT_MAX  = 26;
  localparam int LAT_ZERO = 26;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid, in_valid1;
  logic        in_ready, in_ready1;
  logic [31:0] dividend, divisor;
  logic        out_valid, out_valid1;
  logic        out_ready, out_ready1;
  logic [25:0] quo, quo1;
  logic        sticky, sticky1;
  logic        dbz, dbz1;

  int total = 0;
  int bad   = 0;
  int lat;
  logic [25:0] held_q;

  afpm_sig_divider #(.Q_BITS(26), .TRUNC_BITS(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fp_sig_dividend(dividend), .fp_sig_divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .fp_sig_quotient(quo), .sticky(sticky), .div_by_zero(dbz)
  );

  afpm_sig_divider #(.Q_BITS(26), .TRUNC_BITS(12)) dut_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .fp_sig_dividend(dividend), .fp_sig_divisor(divisor),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .fp_sig_quotient(quo1), .sticky(sticky1), .div_by_zero(dbz1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands to the exact divider; returns #1 after the acceptance edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("rdy_after_take", {31'd0, in_ready}, 32'd1);
    check("vld_after_take", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [25:0] exp_q, input logic exp_s, input int exp_lat);
    start_op(a, b);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, {6'd0, quo}, {6'd0, exp_q});
    check({tag, "_sticky"}, {31'd0, sticky}, {31'd0, exp_s});
    check({tag, "_dbz"}, {31'd0, dbz}, 32'd0);
    take_result();
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0;
    in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0; out_ready1 = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quo", {6'd0, quo}, 32'd0);
    check("rst_sticky", {31'd0, sticky}, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk) reset = 1'b1;

    run_vec("equal",   32'h0080_0000, 32'h0080_0000, 26'h200_0000, 1'b0, LAT_EQ);
    run_vec("maxrat",  32'hFFFF_FFFF, 32'h0080_0000, 26'h3FF_FFFC, 1'b0, LAT_MAX);
    run_vec("inexact", 32'h0080_0000, 32'h00C0_0000, 26'h155_5555, 1'b1, 26);
    run_vec("zerodvd", 32'h0000_0000, 32'h00C0_0000, 26'h000_0000, 1'b0, LAT_ZERO);

    // Truncated divisor: 0xC00801 becomes 0xC01000, so the ratio is exactly 1.
    @(negedge clk);
    dividend  = 32'h00C0_1000;
    divisor   = 32'h00C0_0801;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    check("trunc_done", {31'd0, out_valid1}, 32'd1);
    check("trunc_q", {6'd0, quo1}, 32'h0200_0000);
    check("trunc_sticky", {31'd0, sticky1}, 32'd0);
    @(negedge clk) out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
    check("trunc_rdy", {31'd0, in_ready1}, 32'd1);

    // Divide by zero, then hold off the consumer for five cycles.
    start_op(32'h0012_3456, 32'hFF00_0000);
    wait_done(lat);
    check("dbz_lat", lat, 32'd1);
    check("dbz_flag", {31'd0, dbz}, 32'd1);
    check("dbz_q", {6'd0, quo}, 32'h03FF_FFFF);
    check("dbz_sticky", {31'd0, sticky}, 32'd1);
    held_q = quo;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_q", {6'd0, quo}, {6'd0, held_q});
      check("bp_dbz", {31'd0, dbz}, 32'd1);
    end
    take_result();

    // Reset in the middle of a 26-cycle division.
    start_op(32'h0080_0000, 32'h00C0_0000);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_quo", {6'd0, quo}, 32'd0);
    check("mid_sticky", {31'd0, sticky}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 check("mid_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_vec("post_rst", 32'h0080_0000, 32'h0080_0000, 26'h200_0000, 1'b0, LAT_EQ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
